tag_route_buffer: RTL

- Consumes the tagged stream produced by the tag-attach stage. Input word is {tag, data}, with the tag in the MSBs.
- Looks up the tag in a static routing table and steers the untagged payload into a per-output FIFO.
- Sits between the tagging stage and the consumers (PEs or switch ports) that handle the tagged/temporal traffic.
- Words whose tag is unmapped are dropped and flagged with a sticky error.

---
 rtl/tag_route_buffer_if.sv | 30 +++
 rtl/tag_route_buffer.sv | 89 ++++++++
 2 files changed

// File: rtl/tag_route_buffer_if.sv
// tag_route_buffer_if: input stream, per-port output streams, routing table and error flags of tag_route_buffer
// Signals:
//   in_valid/in_ready/in_data    - tagged input stream, in_data = {tag, payload}
//   out_valid/out_ready/out_data - N_OUT payload streams, port k at out_data[k*DATA_W +: DATA_W]
//   cfg_route                    - 2**TAG_W entries of {en, idx}
//   err_valid/err_tag            - sticky unmapped-tag flag and first offending tag
interface tag_route_buffer_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int N_OUT  = 2
);
    localparam int IDX_W = N_OUT > 1 ? $clog2(N_OUT) : 1;
    logic                             in_valid;
    logic                             in_ready;
    logic [TAG_W+DATA_W-1:0]          in_data;
    logic [N_OUT-1:0]                 out_valid;
    logic [N_OUT-1:0]                 out_ready;
    logic [N_OUT*DATA_W-1:0]          out_data;
    logic [(2**TAG_W)*(1+IDX_W)-1:0]  cfg_route;
    logic                             err_valid;
    logic [TAG_W-1:0]                 err_tag;
    modport master (
        output in_valid, in_data, out_ready, cfg_route,
        input  in_ready, out_valid, out_data, err_valid, err_tag
    );
    modport slave (
        input  in_valid, in_data, out_ready, cfg_route,
        output in_ready, out_valid, out_data, err_valid, err_tag
    );
endinterface

// File: rtl/tag_route_buffer.sv
// tag_route_buffer: looks up each word's tag in a routing table and steers its payload into a per-output FIFO
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - tag_route_buffer_if.slave (input stream, per-port output streams, cfg_route, err_valid/err_tag)
module tag_route_buffer #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int N_OUT  = 2,
    parameter int DEPTH  = 4
) (
    input logic               clk,
    input logic               rst_n,
    tag_route_buffer_if.slave bus
);
    localparam int IDX_W = N_OUT > 1 ? $clog2(N_OUT) : 1;
    localparam int ENT_W = 1 + IDX_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    logic [2**TAG_W-1:0][ENT_W-1:0] route_tbl;
    logic [TAG_W-1:0]               tag;
    logic [DATA_W-1:0]              payload;
    logic [IDX_W-1:0]               idx;
    logic                           mapped;
    logic                           accept;
    logic                           drop;
    logic [N_OUT-1:0]               full;
    logic [N_OUT-1:0]               push;
    logic [N_OUT-1:0]               valid;
    logic [N_OUT-1:0][DATA_W-1:0]   head;
    logic                           err_valid_q, err_valid_d;
    logic [TAG_W-1:0]               err_tag_q, err_tag_d;
    assign route_tbl = bus.cfg_route;
    assign {tag, payload} = bus.in_data;
    assign idx = route_tbl[tag][IDX_W-1:0];
    // idx values beyond N_OUT are treated like a disabled entry
    assign mapped = route_tbl[tag][IDX_W] && int'(idx) < N_OUT;
    // unmapped words are always accepted so they can be dropped
    assign bus.in_ready = !mapped || !full[idx];
    assign accept = bus.in_valid && bus.in_ready;
    assign drop = accept && !mapped;
    assign err_valid_d = err_valid_q || drop;
    assign err_tag_d = (drop && !err_valid_q) ? tag : err_tag_q;
    assign bus.out_valid = valid;
    assign bus.out_data = head;
    assign bus.err_valid = err_valid_q;
    assign bus.err_tag = err_tag_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_tag_q   <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_tag_q   <= err_tag_d;
        end
    end
    for (genvar k = 0; k < N_OUT; k++) begin : g_port
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]  count_q, count_d;
        logic              pop;
        // full blocks pushes even when the same cycle pops
        assign full[k] = count_q == CNT_W'(DEPTH);
        assign push[k] = accept && mapped && int'(idx) == k;
        assign valid[k] = count_q != '0;
        assign pop = valid[k] && bus.out_ready[k];
        assign head[k] = valid[k] ? mem_q[rd_ptr_q] : '0;
        always_comb begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push[k]);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push[k]) - CNT_W'(pop);
        end
        always_ff @(posedge clk) begin
            if (push[k]) mem_q[wr_ptr_q] <= payload;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end
    end
endmodule
